// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Optional checksum byte is enabled by defining IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 16;

    localparam logic [WORD_W-1:0] DEFAULT_BASE_ADDR = 16'h0000;

    typedef enum logic [3:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA_HI,
        DATA_LO,
        WRITE,
        CHK,
        DONE,
        ERR
    } state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Host byte stream (valid/ready) plus instruction-BRAM write port.
// master = host/memory side, slave = loader.
interface imem_loader_if import imem_loader_pkg::*;;

    logic [BYTE_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [WORD_W-1:0] imem_wdata;
    logic [WORD_W-1:0] imem_addr;
    logic              imem_wren;

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, imem_wdata, imem_addr, imem_wren
    );

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, imem_wdata, imem_addr, imem_wren
    );

endinterface

// File: rtl/imem_loader_asm.sv
// Byte-to-word assembler: latches the high byte, presents {hi,lo} and,
// with IMEM_LOADER_CHECKSUM_EN, keeps a running XOR of all data bytes.
module imem_loader_asm import imem_loader_pkg::*; (
    input  logic              clk,
    input  logic              rst_n,
`ifdef IMEM_LOADER_CHECKSUM_EN
    input  logic              csum_clr,
    output logic [BYTE_W-1:0] csum,
`endif
    input  logic              hi_en,
    input  logic              lo_en,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [WORD_W-1:0] word
);

    logic [BYTE_W-1:0] hi_q, hi_d;
    logic [WORD_W-1:0] word_q, word_d;

    always_comb begin
        hi_d   = hi_q;
        word_d = word_q;
        if (hi_en) hi_d = byte_in;
        if (lo_en) word_d = {hi_q, byte_in};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q   <= '0;
            word_q <= '0;
        end else begin
            hi_q   <= hi_d;
            word_q <= word_d;
        end
    end

    assign word = word_q;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (csum_clr)            csum_d = '0;
        else if (hi_en || lo_en) csum_d = csum_q ^ byte_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) csum_q <= '0;
        else        csum_q <= csum_d;
    end

    assign csum = csum_q;
`endif

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed 16-bit instruction image into BRAM and holds the CPU
// until a well-formed image is in place. Define IMEM_LOADER_CHECKSUM_EN for a trailing XOR byte.
module imem_loader import imem_loader_pkg::*; #(
    parameter int unsigned       MAX_WORDS     = 256,
    parameter logic [WORD_W-1:0] BASE_ADDR     = DEFAULT_BASE_ADDR,
    parameter bit                HOLD_AT_RESET = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    imem_loader_if.slave bus,
    output logic         cpu_hold,
    output logic         done,
    output logic         err
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_e AFTER_DATA = CHK;
    logic [BYTE_W-1:0] csum;
    logic              csum_clr;
`else
    localparam state_e AFTER_DATA = DONE;
`endif

    state_e            state_q, state_d;
    logic [WORD_W-1:0] len_q, len_d;
    logic [WORD_W-1:0] idx_q, idx_d;
    logic [WORD_W-1:0] addr_q, addr_d;
    logic              hold_q, hold_d;
    logic [WORD_W-1:0] len_rx;
    logic              rx_ready, xfer, hi_en, lo_en;

    assign xfer = bus.rx_valid & rx_ready;

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        idx_d    = idx_q;
        addr_d   = addr_q;
        hold_d   = hold_q;
        len_rx   = {len_q[WORD_W-1:BYTE_W], bus.rx_data};
        hi_en    = 1'b0;
        lo_en    = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_clr = 1'b0;
`endif
        rx_ready = (state_q == LEN_HI) || (state_q == LEN_LO) || (state_q == DATA_HI) ||
                   (state_q == DATA_LO) || (state_q == CHK);

        case (state_q)
            IDLE, DONE, ERR: if (start) begin
                state_d  = LEN_HI;
                hold_d   = 1'b1;
                addr_d   = BASE_ADDR;
                idx_d    = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                csum_clr = 1'b1;
`endif
            end
            LEN_HI: if (xfer) begin
                len_d[WORD_W-1:BYTE_W] = bus.rx_data;
                state_d = LEN_LO;
            end
            LEN_LO: if (xfer) begin
                len_d = len_rx;
                if (len_rx == '0)                  state_d = AFTER_DATA;
                else if (32'(len_rx) > MAX_WORDS)  state_d = ERR;
                else                               state_d = DATA_HI;
            end
            DATA_HI: if (xfer) begin
                hi_en   = 1'b1;
                state_d = DATA_LO;
            end
            DATA_LO: if (xfer) begin
                lo_en   = 1'b1;
                state_d = WRITE;
            end
            WRITE: begin
                idx_d   = idx_q + 16'd1;
                addr_d  = addr_q + 16'd2;
                state_d = (idx_d == len_q) ? AFTER_DATA : DATA_HI;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK: if (xfer) begin
                state_d = (bus.rx_data == csum) ? DONE : ERR;
            end
`endif
            default: ;
        endcase

        // The CPU is released only on the transition into DONE; ERR keeps it stalled.
        if (state_d == DONE && state_q != DONE) hold_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            addr_q  <= BASE_ADDR;
            hold_q  <= HOLD_AT_RESET;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            hold_q  <= hold_d;
        end
    end

    imem_loader_asm u_asm (
        .clk      (clk),
        .rst_n    (rst_n),
`ifdef IMEM_LOADER_CHECKSUM_EN
        .csum_clr (csum_clr),
        .csum     (csum),
`endif
        .hi_en    (hi_en),
        .lo_en    (lo_en),
        .byte_in  (bus.rx_data),
        .word     (bus.imem_wdata)
    );

    assign bus.rx_ready  = rx_ready;
    assign bus.imem_addr = addr_q;
    assign bus.imem_wren = (state_q == WRITE);
    assign cpu_hold      = hold_q;
    assign done          = (state_q == DONE);
    assign err           = (state_q == ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected BRAM writes are queued as words are sent
// and popped by a write monitor; frame outcomes are checked after each frame.
module tb_imem_loader;

    localparam int unsigned MAXW = 256;
    localparam logic [15:0] BASE = 16'h0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic cpu_hold, done, err;

    imem_loader_if bus ();

    imem_loader #(
        .MAX_WORDS     (MAXW),
        .BASE_ADDR     (BASE),
        .HOLD_AT_RESET (1'b1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bus      (bus),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned passes = 0;
    int unsigned wr_cnt = 0;
    logic        prev_wren = 1'b0;
    logic [31:0] sb [$];
    logic [15:0] wbuf [0:MAXW-1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // Write monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        logic [31:0] e;
        if (bus.imem_wren === 1'b1) begin
            wr_cnt++;
            check("wren_pulse", {31'd0, prev_wren}, 0);
            check("rdy_in_write", {31'd0, bus.rx_ready}, 0);
            if (sb.size() == 0) begin
                check("sb_underflow", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                check("wr_addr", {16'd0, bus.imem_addr}, {16'd0, e[31:16]});
                check("wr_data", {16'd0, bus.imem_wdata}, {16'd0, e[15:0]});
            end
        end
        prev_wren = bus.imem_wren;
    end

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int unsigned n = 0;
        if (gap) begin
            bus.rx_valid = 1'b0;
            @(negedge clk);
        end
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        while (bus.rx_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("rx_timeout", n, 0);
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_frame(input int unsigned n, input bit gap, input bit bad, input bit poke);
        logic [7:0]  acc = 8'h00;
        logic [15:0] nn  = 16'(n);
        logic [15:0] w;
        do_start();
        send_byte(nn[15:8], gap);
        send_byte(nn[7:0], gap);
        if (n <= MAXW) begin
            for (int unsigned i = 0; i < n; i++) begin
                if (poke && i == 1) do_start();
                w = wbuf[i];
                sb.push_back({BASE + 16'(2 * i), w});
                send_byte(w[15:8], gap);
                send_byte(w[7:0], gap);
                acc = acc ^ w[15:8] ^ w[7:0];
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            send_byte(bad ? (acc ^ 8'h01) : acc, gap);
`else
            if (bad) acc = ~acc;
`endif
        end
    endtask

    task automatic wait_end();
        int unsigned n = 0;
        while (!(done || err) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!(done || err)) check("end_timeout", n, 0);
        @(negedge clk);
    endtask

    task automatic expect_end(input string tag, input bit exp_done, input bit exp_err,
                              input bit exp_hold, input int unsigned exp_wr, input int unsigned wr0);
        check({tag, "_done"}, {31'd0, done}, {31'd0, exp_done});
        check({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
        check({tag, "_hold"}, {31'd0, cpu_hold}, {31'd0, exp_hold});
        check({tag, "_sb_left"}, sb.size(), 0);
        check({tag, "_wr_cnt"}, wr_cnt - wr0, exp_wr);
    endtask

    initial begin
        int unsigned c0;
        int unsigned n;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;

        // reset values, checked during and after reset with no start
        repeat (2) @(negedge clk);
        check("rst_hold", {31'd0, cpu_hold}, 1);
        check("rst_addr", {16'd0, bus.imem_addr}, {16'd0, BASE});
        check("rst_wdata", {16'd0, bus.imem_wdata}, 0);
        rst_n = 1'b1;
        bus.rx_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_ready", {31'd0, bus.rx_ready}, 0);
        check("idle_wren", {31'd0, bus.imem_wren}, 0);
        check("idle_done", {31'd0, done}, 0);
        check("idle_err", {31'd0, err}, 0);
        check("idle_hold", {31'd0, cpu_hold}, 1);
        bus.rx_valid = 1'b0;

        // two-word frame at full rate
        wbuf[0] = 16'h1234;
        wbuf[1] = 16'hABCD;
        c0 = wr_cnt;
        send_frame(2, 1'b0, 1'b0, 1'b0);
        wait_end();
        expect_end("full", 1'b1, 1'b0, 1'b0, 2, c0);

        // same frame, valid every other cycle, with an ignored start mid-frame
        c0 = wr_cnt;
        send_frame(2, 1'b1, 1'b0, 1'b1);
        wait_end();
        expect_end("gap", 1'b1, 1'b0, 1'b0, 2, c0);

        // length 257 exceeds MAX_WORDS
        c0 = wr_cnt;
        send_frame(257, 1'b0, 1'b0, 1'b0);
        wait_end();
        expect_end("toolong", 1'b0, 1'b1, 1'b1, 0, c0);

        // a valid frame afterwards clears err
        wbuf[0] = 16'h5A5A;
        c0 = wr_cnt;
        send_frame(1, 1'b0, 1'b0, 1'b0);
        wait_end();
        expect_end("recover", 1'b1, 1'b0, 1'b0, 1, c0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // wrong checksum: words land in memory but the frame is rejected
        wbuf[0] = 16'h1234;
        wbuf[1] = 16'hABCD;
        c0 = wr_cnt;
        send_frame(2, 1'b0, 1'b1, 1'b0);
        wait_end();
        expect_end("badcsum", 1'b0, 1'b1, 1'b1, 2, c0);
`endif

        // empty image
        c0 = wr_cnt;
        send_frame(0, 1'b0, 1'b0, 1'b0);
        wait_end();
        expect_end("empty", 1'b1, 1'b0, 1'b0, 0, c0);

        // largest accepted image
        for (int unsigned i = 0; i < MAXW; i++) wbuf[i] = 16'(i * 16'h0101) ^ 16'h8001;
        c0 = wr_cnt;
        send_frame(MAXW, 1'b0, 1'b0, 1'b0);
        wait_end();
        expect_end("maxlen", 1'b1, 1'b0, 1'b0, MAXW, c0);

        // reset after the first word of a 3-word frame
        c0 = wr_cnt;
        do_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h03, 1'b0);
        sb.push_back({BASE, 16'h1111});
        send_byte(8'h11, 1'b0);
        send_byte(8'h11, 1'b0);
        n = 0;
        while (wr_cnt == c0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("midrst_wr", wr_cnt - c0, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_ready", {31'd0, bus.rx_ready}, 0);
        check("midrst_hold", {31'd0, cpu_hold}, 1);
        check("midrst_addr", {16'd0, bus.imem_addr}, {16'd0, BASE});
        check("midrst_done", {31'd0, done}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wbuf[0] = 16'h2222;
        c0 = wr_cnt;
        send_frame(1, 1'b0, 1'b0, 1'b0);
        wait_end();
        expect_end("afterrst", 1'b1, 1'b0, 1'b0, 1, c0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction-memory port consumed by the fetch stage.
- Receives a byte stream from a host link (UART/SPI receiver) over a valid/ready handshake and assembles 16-bit instruction words.
- Writes each word into the instruction BRAM via imem_wdata/imem_addr/imem_wren.
- Holds the CPU in stall (cpu_hold) until a complete, well-formed image is loaded.

Parameters:
- MAX_WORDS, 256, largest accepted image length in 16-bit words.
- BASE_ADDR, 16'h0000, byte address of the first word written.
- HOLD_AT_RESET, 1, reset value of cpu_hold (1 = CPU stalled until first successful load).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- start  in  1  single-cycle pulse; begins a load frame when idle, done, or in error
- rx_data  in  8  incoming byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader accepts rx_data this cycle
- imem_wdata  out  16  instruction word to write
- imem_addr  out  16  byte address of write (even; steps of 2)
- imem_wren  out  1  one-cycle write strobe
- cpu_hold  out  1  stall request to fetch stage
- done  out  1  image loaded successfully; sticky until next start
- err  out  1  frame rejected; sticky until next start

Behaviour:
- Reset values: rx_ready=0, imem_wdata=0, imem_addr=BASE_ADDR, imem_wren=0, cpu_hold=HOLD_AT_RESET, done=0, err=0, state=IDLE, word count=0.
- Byte transfer occurs on a rising edge where rx_valid & rx_ready are both high.
- rx_ready is high only in LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHK; low in all other states.
- Frame format: LEN_HI, LEN_LO (16-bit word count N, big-endian), then N words each sent high byte first.
- States and transitions:
  - IDLE/DONE/ERR --start--> LEN_HI. Entering LEN_HI clears done and err, sets cpu_hold=1, sets imem_addr=BASE_ADDR, sets idx=0.
  - LEN_HI --xfer--> LEN_LO.
  - LEN_LO --xfer--> one of:
    - N==0: DONE.
    - N>MAX_WORDS: ERR.
    - otherwise: DATA_HI.
  - DATA_HI --xfer--> DATA_LO.
  - DATA_LO --xfer--> WRITE.
  - WRITE: for exactly one cycle, imem_wren=1, imem_wdata={hi,lo}, imem_addr=BASE_ADDR+2*idx. Next cycle: idx+1; if idx+1==N go to CHK_OR_DONE, else DATA_HI.
  - CHK_OR_DONE: DONE when checksum is compiled out (see Optional Feature).
  - DONE: done=1, cpu_hold=0.
  - ERR: err=1, cpu_hold stays 1.
- Latency: the write strobe occurs 1 cycle after the low-byte transfer. Minimum 3 cycles per word at full rx_valid rate.
- start while in LEN_*/DATA_*/WRITE/CHK is ignored; the frame in progress continues.
- rx_valid outside the ready states: the byte is not consumed and no state change occurs.
- Address arithmetic is 16-bit modulo; it wraps with no error, since N≤MAX_WORDS bounds usage.
- Asynchronous reset mid-frame: return to IDLE with reset values. Partially written BRAM contents are left unchanged.
- imem_wren is never asserted outside WRITE.

Optional Feature:
- Macro IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - After the last word, state CHK accepts one byte.
  - A running XOR of all data bytes (not length bytes) is kept, cleared on start.
  - Byte equals running XOR: go to DONE. Otherwise: go to ERR.
  - Words are already written either way; cpu_hold stays 1 on mismatch.
  - N==0 also expects a checksum byte, which must be 8'h00.
- Not defined: no checksum byte. DONE follows the last WRITE (N>0) or LEN_LO (N==0) directly.

Decomposition:
- Shared package imem_loader_pkg:
  - state enum (IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CHK, DONE, ERR).
  - constants for byte/word widths and default BASE_ADDR.
- One natural sub-module: imem_loader_asm, the byte-to-word assembler. It holds the high-byte register and running XOR, and presents {hi,lo}. The FSM and address counter stay in the top module.

Test Plan:
- Reset, no start -> cpu_hold=HOLD_AT_RESET(1), imem_wren=0, rx_ready=0, done=0, err=0.
- start; bytes 00 02 12 34 AB CD (checksum byte CD^AB^34^12=0x40 when macro on) -> writes 16'h1234@0x0000, then 16'hABCD@0x0002, one wren pulse each; then done=1, cpu_hold=0.
- rx_valid toggling every other cycle across same frame -> identical writes/addresses; rx_ready never high in WRITE.
- start; length 01 01 (257 > MAX_WORDS) -> err=1, no wren, cpu_hold=1; later start with valid frame clears err.
- Macro on: valid 2-word frame with checksum byte 0x41 -> both words written, err=1, done=0, cpu_hold=1.
- rst_n asserted after first word written -> state IDLE, rx_ready=0, cpu_hold=1; start with new frame writes again from BASE_ADDR.
